// File: rtl/beat_pkg.sv
// beat_pkg: shared definitions for the beat sequencer.
//   - default sizing (DEPTH_DEF, DUR_W_DEF, TICK_DIV_DEF)
//   - beat_state_e: sequencer state encoding as seen on the state port
//   - beat_entry_t: decoded view of one stored note entry {code, dur}
// The entry struct carries the duration in a fixed DUR_MAX_W-bit field so it
// can be shared by every instance regardless of its DUR_W; the memory itself
// stores only CODE_W+DUR_W bits per entry. DUR_W must not exceed DUR_MAX_W.
package beat_pkg;

    localparam int DEPTH_DEF    = 32;
    localparam int DUR_W_DEF    = 10;
    localparam int TICK_DIV_DEF = 500000;

    localparam int CODE_W    = 7;
    localparam int DUR_MAX_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REC  = 2'd1,
        ST_PLAY = 2'd2
    } beat_state_e;

    typedef struct packed {
        logic [CODE_W-1:0]    code;
        logic [DUR_MAX_W-1:0] dur;
    } beat_entry_t;

endpackage

// File: rtl/beat_sequencer_tick_gen.sv
// tick_gen: tick prescaler for the beat sequencer.
//   clk   : system clock
//   reset : synchronous active-high reset, counter to 0
//   clear : synchronous restart of the tick period (counter to 0)
//   tick  : high for one cycle every TICK_DIV cycles; the first tick after a
//           clear/reset arrives in the TICK_DIV-th cycle after it.
module tick_gen #(
    parameter int TICK_DIV = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer: records a live key-code stream as {code, duration} entries
// and plays it back to a tone generator.
//   clk      : system clock (single domain)
//   reset    : synchronous active-high reset
//   ascii    : live key code, 0 = no key
//   record   : one-cycle pulse, start recording (wins over play)
//   play     : one-cycle pulse, start playback (ignored when nothing stored)
//   stop     : one-cycle pulse, end recording/playback
//   note_out : key code for the tone generator
//   state    : 0 IDLE, 1 REC, 2 PLAY
//   count    : number of valid stored entries
//   overflow : sticky, set when a recording filled all DEPTH entries
// Durations are counted in ticks of TICK_DIV clk cycles (TICK_DIV >= 2).
module beat_sequencer
    import beat_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             ascii,
    input  logic                   record,
    input  logic                   play,
    input  logic                   stop,
    output logic [6:0]             note_out,
    output logic [1:0]             state,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int CNT_W  = IDX_W + 1;
    localparam int WORD_W = CODE_W + DUR_W;

    localparam logic [1:0]       S_IDLE   = ST_IDLE;
    localparam logic [1:0]       S_REC    = ST_REC;
    localparam logic [1:0]       S_PLAY   = ST_PLAY;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
    localparam logic [DUR_W-1:0] DUR_MAX  = '1;

    logic [1:0]        state_reg, state_next;
    logic [CODE_W-1:0] note_reg, note_next;
    logic [CODE_W-1:0] cur_code_reg, cur_code_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              overflow_reg, overflow_next;
    logic [DUR_W-1:0]  dur_reg, dur_next;     // REC: segment ticks, PLAY: ticks into entry
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic              fin_reg, fin_next;     // PLAY: last entry done, emit silence

    logic              tick, tick_clear;
    logic              wr_en, rd_en;
    logic [WORD_W-1:0] wr_word, rd_word_reg;
    logic [DUR_W-1:0]  dur_floor1;
    logic              play_last, seg_done;
    beat_entry_t       rd_entry;

    logic [WORD_W-1:0] mem [DEPTH];

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    // A segment closed before its first tick still counts as one tick.
    assign dur_floor1 = (dur_reg == '0) ? DUR_W'(1) : dur_reg;
    assign wr_word    = {cur_code_reg, dur_floor1};
    assign rd_entry   = {rd_word_reg[WORD_W-1:DUR_W], DUR_MAX_W'(rd_word_reg[DUR_W-1:0])};
    assign play_last  = ((CNT_W'(idx_reg) + CNT_W'(1)) == count_reg);
    assign seg_done   = ((DUR_MAX_W'(dur_reg) + DUR_MAX_W'(1)) == rd_entry.dur);

    always_comb begin
        state_next    = state_reg;
        note_next     = note_reg;
        cur_code_next = cur_code_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;
        dur_next      = dur_reg;
        idx_next      = idx_reg;
        fin_next      = fin_reg;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        tick_clear    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                note_next = ascii;
                if (record) begin
                    state_next    = S_REC;
                    count_next    = '0;
                    overflow_next = 1'b0;
                    cur_code_next = ascii;
                    dur_next      = '0;
                    tick_clear    = 1'b1;
                end else if (play && (count_reg != '0)) begin
                    // Fetch entry 0 now so its code reaches note_out two
                    // cycles after the play pulse.
                    state_next = S_PLAY;
                    idx_next   = '0;
                    dur_next   = '0;
                    fin_next   = 1'b0;
                    rd_en      = 1'b1;
                    tick_clear = 1'b1;
                end
            end

            S_REC: begin
                note_next = ascii;
                if (stop) begin
                    wr_en      = 1'b1;
                    state_next = S_IDLE;
                end else if (ascii != cur_code_reg) begin
                    // Takes precedence over a saturated segment: one write.
                    wr_en         = 1'b1;
                    cur_code_next = ascii;
                    dur_next      = '0;
                end else if (dur_reg == DUR_MAX) begin
                    wr_en    = 1'b1;
                    dur_next = '0;
                end else if (tick) begin
                    dur_next = dur_reg + DUR_W'(1);
                end

                if (wr_en) begin
                    count_next = count_reg + CNT_W'(1);
                    if (count_reg == LAST_CNT) begin
                        overflow_next = 1'b1;
                        state_next    = S_IDLE;
                    end
                end
            end

            S_PLAY: begin
                if (stop || fin_reg) begin
                    note_next  = '0;
                    state_next = S_IDLE;
                end else begin
                    note_next = rd_entry.code;
                    if (tick) begin
                        if (seg_done) begin
                            dur_next = '0;
                            if (play_last) begin
                                fin_next = 1'b1;
                            end else begin
                                idx_next = idx_reg + IDX_W'(1);
                                rd_en    = 1'b1;
                            end
                        end else begin
                            dur_next = dur_reg + DUR_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
                note_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            note_reg     <= '0;
            cur_code_reg <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            dur_reg      <= '0;
            idx_reg      <= '0;
            fin_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            note_reg     <= note_next;
            cur_code_reg <= cur_code_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            dur_reg      <= dur_next;
            idx_reg      <= idx_next;
            fin_reg      <= fin_next;
        end
    end

    // Entry memory: no reset, reads only ever target indices below count.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[count_reg[IDX_W-1:0]] <= wr_word;
        end
        if (rd_en && !reset) begin
            rd_word_reg <= mem[idx_next];
        end
    end

    assign note_out = note_reg;
    assign state    = state_reg;
    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_beat_sequencer.sv
module tb_beat_sequencer;

    localparam int TD   = 4;
    localparam int DW   = 4;
    localparam int DP   = 4;
    localparam int MAXD = (1 << DW) - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] ascii = '0;
    logic       record = 1'b0, play = 1'b0, stop = 1'b0;
    logic [6:0] note_out;
    logic [1:0] state;
    logic [2:0] count;
    logic       overflow;

    beat_sequencer #(.DEPTH(DP), .DUR_W(DW), .TICK_DIV(TD)) dut (
        .clk      (clk),
        .reset    (reset),
        .ascii    (ascii),
        .record   (record),
        .play     (play),
        .stop     (stop),
        .note_out (note_out),
        .state    (state),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int note;
        bit last;
    } pq_t;

    int  m_state = 0, m_note = 0, m_count = 0, m_ovf = 0;
    int  m_cur = 0, m_seg = 0, m_k = 0;
    int  m_code [DP];
    int  m_dur  [DP];
    pq_t pq [$];

    task automatic model_step(input bit r, input int a, input bit rc, input bit pl, input bit st);
        bit do_wr;
        int wcode, wdur;
        pq_t it;
        if (r) begin
            m_state = 0; m_note = 0; m_count = 0; m_ovf = 0;
            pq.delete();
            return;
        end
        case (m_state)
            0: begin
                m_note = a;
                if (rc) begin
                    m_state = 1; m_count = 0; m_ovf = 0;
                    m_cur = a; m_seg = 0; m_k = 0;
                end else if (pl && m_count > 0) begin
                    // Whole playback precomputed: each entry lasts dur*TD
                    // cycles, followed by one silent cycle that ends PLAY.
                    m_state = 2;
                    pq.delete();
                    for (int i = 0; i < m_count; i++)
                        for (int j = 0; j < m_dur[i] * TD; j++)
                            pq.push_back('{m_code[i], 1'b0});
                    pq.push_back('{0, 1'b1});
                end
            end
            1: begin
                m_k++;
                m_note = a;
                do_wr = 0;
                wcode = m_cur;
                wdur  = (m_seg == 0) ? 1 : m_seg;
                if (st) begin
                    do_wr = 1; m_state = 0;
                end else if (a != m_cur) begin
                    do_wr = 1; m_cur = a; m_seg = 0;
                end else if (m_seg == MAXD) begin
                    do_wr = 1; m_seg = 0;
                end else if (m_k % TD == 0) begin
                    m_seg++;
                end
                if (do_wr) begin
                    m_code[m_count] = wcode;
                    m_dur[m_count]  = wdur;
                    m_count++;
                    if (m_count == DP) begin
                        m_ovf = 1; m_state = 0;
                    end
                end
            end
            default: begin
                if (st || pq.size() == 0) begin
                    m_note = 0; m_state = 0;
                    pq.delete();
                end else begin
                    it = pq.pop_front();
                    m_note = it.note;
                    if (it.last) m_state = 0;
                end
            end
        endcase
    endtask

    // Apply one cycle of inputs, then check the DUT against the model.
    task automatic step(input bit r, input int a, input bit rc, input bit pl, input bit st);
        reset  = r;
        ascii  = 7'(a);
        record = rc;
        play   = pl;
        stop   = st;
        @(posedge clk);
        #1;
        model_step(r, a, rc, pl, st);
        chk("model.note", int'(note_out), m_note);
        chk("model.state", int'(state), m_state);
        chk("model.count", int'(count), m_count);
        chk("model.overflow", int'(overflow), m_ovf);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rst, rec, ply, stp;
        int asc, cycles;
        int e_note, e_state, e_count, e_ovf;
    } vec_t;

    vec_t vecs [$];

    function automatic void add(input bit r, input int a, input bit rc, input bit pl, input bit st,
                                input int n, input int en, input int es, input int ec, input int eo);
        vec_t v;
        v.rst = r; v.asc = a; v.rec = rc; v.ply = pl; v.stp = st; v.cycles = n;
        v.e_note = en; v.e_state = es; v.e_count = ec; v.e_ovf = eo;
        vecs.push_back(v);
    endfunction

    initial begin
        int cur_a;
        int chg_div;
        int codes [4] = '{0, 65, 66, 67};

        // reset state
        add(1, 0, 0, 0, 0,  2,   0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  1,   0, 0, 0, 0);
        // record 65 x12, 83 x8, stop -> {65,3},{83,2}
        add(0, 65, 1, 0, 0, 1,  65, 1, 0, 0);
        add(0, 65, 0, 0, 0, 12, 65, 1, 0, 0);
        add(0, 83, 0, 0, 0, 1,  83, 1, 1, 0);
        add(0, 83, 0, 0, 0, 7,  83, 1, 1, 0);
        add(0, 83, 0, 0, 1, 1,  83, 0, 2, 0);
        add(0, 0, 0, 0, 0,  2,   0, 0, 2, 0);
        // playback: 65 from play+2 for 12 cycles, 83 for 8, then 0 / IDLE
        add(0, 0, 0, 1, 0,  1,   0, 2, 2, 0);
        add(0, 0, 0, 0, 0,  1,  65, 2, 2, 0);
        add(0, 0, 0, 0, 0,  11, 65, 2, 2, 0);
        add(0, 0, 0, 0, 0,  1,  83, 2, 2, 0);
        add(0, 0, 0, 0, 0,  7,  83, 2, 2, 0);
        add(0, 0, 0, 0, 0,  1,   0, 0, 2, 0);
        add(0, 9, 0, 0, 0,  1,   9, 0, 2, 0);
        // stop mid-PLAY; record/play during PLAY ignored
        add(0, 0, 0, 1, 0,  1,   0, 2, 2, 0);
        add(0, 0, 0, 0, 0,  5,  65, 2, 2, 0);
        add(0, 0, 1, 1, 0,  1,  65, 2, 2, 0);
        add(0, 0, 0, 0, 1,  1,   0, 0, 2, 0);
        // record and play together -> REC; stop at once stores dur 1
        add(0, 66, 1, 1, 0, 1,  66, 1, 0, 0);
        add(0, 66, 0, 0, 1, 1,  66, 0, 1, 0);
        // play with nothing stored is ignored
        add(1, 0, 0, 0, 0,  1,   0, 0, 0, 0);
        add(0, 5, 0, 1, 0,  1,   5, 0, 0, 0);
        // 72 held 70 cycles -> {72,15},{72,2}, then play it back
        add(0, 72, 1, 0, 0, 1,  72, 1, 0, 0);
        add(0, 72, 0, 0, 0, 70, 72, 1, 1, 0);
        add(0, 72, 0, 0, 1, 1,  72, 0, 2, 0);
        add(0, 0, 0, 1, 0,  1,   0, 2, 2, 0);
        add(0, 0, 0, 0, 0,  1,  72, 2, 2, 0);
        add(0, 0, 0, 0, 0,  67, 72, 2, 2, 0);
        add(0, 0, 0, 0, 0,  1,   0, 0, 2, 0);
        // overflow: 4th write fills memory, 5th change not stored
        add(0, 1, 1, 0, 0,  1,   1, 1, 0, 0);
        add(0, 2, 0, 0, 0,  1,   2, 1, 1, 0);
        add(0, 3, 0, 0, 0,  1,   3, 1, 2, 0);
        add(0, 4, 0, 0, 0,  1,   4, 1, 3, 0);
        add(0, 5, 0, 0, 0,  1,   5, 0, 4, 1);
        add(0, 6, 0, 0, 0,  1,   6, 0, 4, 1);
        add(0, 0, 0, 1, 0,  1,   0, 2, 4, 1);
        add(0, 0, 0, 0, 0,  17,  0, 0, 4, 1);
        // reset mid-PLAY
        add(0, 0, 0, 1, 0,  1,   0, 2, 4, 1);
        add(0, 0, 0, 0, 0,  6,   2, 2, 4, 1);
        add(1, 0, 0, 0, 0,  1,   0, 0, 0, 0);
        // reset mid-REC
        add(0, 70, 1, 0, 0, 1,  70, 1, 0, 0);
        add(0, 71, 0, 0, 0, 3,  71, 1, 1, 0);
        add(1, 71, 0, 0, 0, 1,   0, 0, 0, 0);
        add(0, 0, 0, 0, 0,  1,   0, 0, 0, 0);
        // code change in the cycle the segment is saturated: one write only
        add(0, 72, 1, 0, 0, 1,  72, 1, 0, 0);
        add(0, 72, 0, 0, 0, 60, 72, 1, 0, 0);
        add(0, 73, 0, 0, 0, 1,  73, 1, 1, 0);
        add(0, 73, 0, 0, 1, 1,  73, 0, 2, 0);

        #2;
        for (int vi = 0; vi < vecs.size(); vi++) begin
            for (int c = 0; c < vecs[vi].cycles; c++) begin
                // pulses only on the first cycle of a multi-cycle row
                step(vecs[vi].rst, vecs[vi].asc,
                     (c == 0) ? vecs[vi].rec : 1'b0,
                     (c == 0) ? vecs[vi].ply : 1'b0,
                     (c == 0) ? vecs[vi].stp : 1'b0);
            end
            chk($sformatf("vec%0d.note", vi), int'(note_out), vecs[vi].e_note);
            chk($sformatf("vec%0d.state", vi), int'(state), vecs[vi].e_state);
            chk($sformatf("vec%0d.count", vi), int'(count), vecs[vi].e_count);
            chk($sformatf("vec%0d.overflow", vi), int'(overflow), vecs[vi].e_ovf);
            $display("vec %0d: note=%0d state=%0d count=%0d overflow=%0d",
                     vi, note_out, state, count, overflow);
        end

        // randomized traffic: fast-changing keys, then long holds that
        // reach duration saturation
        cur_a = 0;
        for (int blk = 0; blk < 2; blk++) begin
            chg_div = (blk == 0) ? 8 : 120;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(chg_div - 1) == 0)
                    cur_a = codes[$urandom_range(3)];
                step($urandom_range(399) == 0, cur_a,
                     $urandom_range(59) == 0,
                     $urandom_range(39) == 0,
                     $urandom_range((blk == 0) ? 49 : 199) == 0);
            end
            $display("random block %0d: compared=%0d mismatched=%0d", blk, n_cmp, n_bad);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
